mcpu_ctrl: RTL and testbench

Multi-cycle control unit for the RV32I-subset CPU (R-type, I-ALU, LW, SW, BEQ, JAL). It sequences the shared datapath (single ALU, unified memory port, IR/ALUOut/OldPC registers) through a state machine. Memory accesses are gated by the MIO_ready handshake. ALU_Control and ImmSel use the same encodings as the single-cycle controller.

---
 rtl/mcpu_ctrl_if.sv | 32 +++
 rtl/mcpu_ctrl.sv | 160 ++++++++++++++++
 tb/tb_mcpu_ctrl.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/mcpu_ctrl_if.sv
// mcpu_ctrl_if: control bundle between the multi-cycle controller (master) and the datapath (slave).
interface mcpu_ctrl_if;
    logic [4:0] OPcode;
    logic [2:0] Fun3;
    logic       Fun7;
    logic       MIO_ready;
    logic       PCWrite;
    logic       PCWriteCond;
    logic [1:0] PCSource;
    logic       IorD;
    logic       MemRW;
    logic       CPU_MIO;
    logic       IRWrite;
    logic       RegWrite;
    logic [1:0] MemtoReg;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ImmSel;
    logic [2:0] ALU_Control;
    logic [3:0] state_o;
    logic       illegal;
    modport master (
        input  OPcode, Fun3, Fun7, MIO_ready,
        output PCWrite, PCWriteCond, PCSource, IorD, MemRW, CPU_MIO, IRWrite, RegWrite,
               MemtoReg, ALUSrcA, ALUSrcB, ImmSel, ALU_Control, state_o, illegal
    );
    modport slave (
        output OPcode, Fun3, Fun7, MIO_ready,
        input  PCWrite, PCWriteCond, PCSource, IorD, MemRW, CPU_MIO, IRWrite, RegWrite,
               MemtoReg, ALUSrcA, ALUSrcB, ImmSel, ALU_Control, state_o, illegal
    );
endinterface

// File: rtl/mcpu_ctrl.sv
// mcpu_ctrl: multi-cycle RV32I-subset control FSM sequencing a shared ALU/memory datapath.
// Define MCPU_ILLEGAL_TRAP_EN to trap unknown opcodes in a sticky TRAP state.
module mcpu_ctrl #(
    parameter int IF_WAIT_MAX = 0
) (
    input logic         clk,
    input logic         rst,
    mcpu_ctrl_if.master bus
);
    localparam int unused_if_wait_max = IF_WAIT_MAX;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    typedef enum logic [3:0] {
        S_IF = 4'd0, S_ID = 4'd1, S_EX_R = 4'd2, S_EX_I = 4'd3, S_MEM_ADDR = 4'd4,
        S_MEM_RD = 4'd5, S_WB_LD = 4'd6, S_MEM_WR = 4'd7, S_WB_ALU = 4'd8, S_BR = 4'd9,
        S_JAL = 4'd10
`ifdef MCPU_ILLEGAL_TRAP_EN
        , S_TRAP = 4'd15
`endif
    } state_t;
`ifdef MCPU_ILLEGAL_TRAP_EN
    localparam state_t S_BAD = S_TRAP;
`else
    localparam state_t S_BAD = S_IF;
`endif
    state_t     state_q, state_d;
    logic       is_r, is_i, is_lw, is_sw, is_br, is_jal;
    logic [3:0] fn_r;
    logic [2:0] alu_r, alu_i;
    assign is_r   = bus.OPcode == 5'b01100;
    assign is_i   = bus.OPcode == 5'b00100;
    assign is_lw  = bus.OPcode == 5'b00000;
    assign is_sw  = bus.OPcode == 5'b01000;
    assign is_br  = bus.OPcode == 5'b11000;
    assign is_jal = bus.OPcode == 5'b11011;
    assign fn_r   = {bus.Fun3, bus.Fun7};
    assign alu_r  = fn_r == 4'b0001 ? ALU_SUB :
                    fn_r == 4'b0100 ? 3'b111 :
                    fn_r == 4'b1000 ? 3'b011 :
                    fn_r == 4'b1010 ? 3'b101 :
                    fn_r == 4'b1100 ? 3'b001 :
                    fn_r == 4'b1110 ? 3'b000 : ALU_ADD;
    assign alu_i  = bus.Fun3 == 3'b010 ? 3'b111 :
                    bus.Fun3 == 3'b100 ? 3'b011 :
                    bus.Fun3 == 3'b101 ? 3'b101 :
                    bus.Fun3 == 3'b110 ? 3'b001 :
                    bus.Fun3 == 3'b111 ? 3'b000 : ALU_ADD;
    assign bus.state_o = state_q;
    always_ff @(posedge clk or posedge rst)
        if (rst) state_q <= S_IF;
        else     state_q <= state_d;
`ifdef MCPU_ILLEGAL_TRAP_EN
    logic illegal_q;
    always_ff @(posedge clk or posedge rst)
        if (rst)                    illegal_q <= 1'b0;
        else if (state_d == S_TRAP) illegal_q <= 1'b1;
    assign bus.illegal = illegal_q;
`else
    assign bus.illegal = 1'b0;
`endif
    always_comb begin
        state_d         = state_q;
        bus.PCWrite     = 1'b0;
        bus.PCWriteCond = 1'b0;
        bus.PCSource    = 2'b00;
        bus.IorD        = 1'b0;
        bus.MemRW       = 1'b0;
        bus.CPU_MIO     = 1'b0;
        bus.IRWrite     = 1'b0;
        bus.RegWrite    = 1'b0;
        bus.MemtoReg    = 2'b00;
        bus.ALUSrcA     = 2'b00;
        bus.ALUSrcB     = 2'b00;
        bus.ImmSel      = 2'b00;
        bus.ALU_Control = 3'b000;
        case (state_q)
            S_IF: begin
                state_d         = bus.MIO_ready ? S_ID : S_IF;
                bus.CPU_MIO     = 1'b1;
                bus.ALUSrcB     = 2'b01;
                bus.ALU_Control = ALU_ADD;
                bus.IRWrite     = bus.MIO_ready;
                bus.PCWrite     = bus.MIO_ready;
            end
            S_ID: begin
                // ALUOut captures OldPC+imm so BR/JAL already have their target
                state_d         = is_r ? S_EX_R : is_i ? S_EX_I : (is_lw || is_sw) ? S_MEM_ADDR :
                                  is_br ? S_BR : is_jal ? S_JAL : S_BAD;
                bus.ALUSrcA     = 2'b10;
                bus.ALUSrcB     = 2'b10;
                bus.ALU_Control = ALU_ADD;
                bus.ImmSel      = is_br ? 2'b10 : is_jal ? 2'b11 : 2'b00;
            end
            S_EX_R: begin
                state_d         = S_WB_ALU;
                bus.ALUSrcA     = 2'b01;
                bus.ALU_Control = alu_r;
            end
            S_EX_I: begin
                state_d         = S_WB_ALU;
                bus.ALUSrcA     = 2'b01;
                bus.ALUSrcB     = 2'b10;
                bus.ALU_Control = alu_i;
            end
            S_MEM_ADDR: begin
                state_d         = is_sw ? S_MEM_WR : S_MEM_RD;
                bus.ALUSrcA     = 2'b01;
                bus.ALUSrcB     = 2'b10;
                bus.ALU_Control = ALU_ADD;
                bus.ImmSel      = is_sw ? 2'b01 : 2'b00;
            end
            S_MEM_RD: begin
                state_d     = bus.MIO_ready ? S_WB_LD : S_MEM_RD;
                bus.CPU_MIO = 1'b1;
                bus.IorD    = 1'b1;
            end
            S_WB_LD: begin
                state_d      = S_IF;
                bus.RegWrite = 1'b1;
                bus.MemtoReg = 2'b01;
            end
            S_MEM_WR: begin
                state_d     = bus.MIO_ready ? S_IF : S_MEM_WR;
                bus.CPU_MIO = 1'b1;
                bus.IorD    = 1'b1;
                bus.MemRW   = 1'b1;
            end
            S_WB_ALU: begin
                state_d      = S_IF;
                bus.RegWrite = 1'b1;
            end
            S_BR: begin
                state_d         = S_IF;
                bus.ALUSrcA     = 2'b01;
                bus.ALU_Control = ALU_SUB;
                bus.PCWriteCond = 1'b1;
                bus.PCSource    = 2'b01;
                bus.ImmSel      = 2'b10;
            end
            S_JAL: begin
                state_d      = S_IF;
                bus.RegWrite = 1'b1;
                bus.MemtoReg = 2'b10;
                bus.PCWrite  = 1'b1;
                bus.PCSource = 2'b01;
                bus.ImmSel   = 2'b11;
            end
            default: state_d = S_BAD;
        endcase
        // strobes must be quiet for the whole reset pulse, not just after the next edge
        if (rst) begin
            bus.PCWrite     = 1'b0;
            bus.PCWriteCond = 1'b0;
            bus.IRWrite     = 1'b0;
            bus.RegWrite    = 1'b0;
            bus.MemRW       = 1'b0;
            bus.CPU_MIO     = 1'b0;
        end
    end
endmodule

// File: tb/tb_mcpu_ctrl.sv
// tb_mcpu_ctrl: randomized instruction streams against an instruction-level control model, scoreboard-checked.
module tb_mcpu_ctrl;
    localparam logic [4:0] OP_R = 5'b01100, OP_I = 5'b00100, OP_LW = 5'b00000, OP_SW = 5'b01000;
    localparam logic [4:0] OP_BR = 5'b11000, OP_JAL = 5'b11011;
    logic clk = 1'b0;
    logic rst = 1'b1;
    mcpu_ctrl_if bus ();
    mcpu_ctrl dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    logic [24:0] sbq[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    event        chk_ev;
    logic [4:0]  op_c = 5'b0;
    logic [2:0]  f3_c = 3'b0;
    logic        f7_c = 1'b0;
    logic        ill_exp = 1'b0;
    function automatic logic [2:0] ref_r(logic [2:0] f3, logic f7);
        case ({f3, f7})
            4'b0000: return 3'b010;
            4'b0001: return 3'b110;
            4'b0100: return 3'b111;
            4'b1000: return 3'b011;
            4'b1010: return 3'b101;
            4'b1100: return 3'b001;
            4'b1110: return 3'b000;
            default: return 3'b010;
        endcase
    endfunction
    function automatic logic [2:0] ref_i(logic [2:0] f3);
        case (f3)
            3'b010:  return 3'b111;
            3'b100:  return 3'b011;
            3'b101:  return 3'b101;
            3'b110:  return 3'b001;
            3'b111:  return 3'b000;
            default: return 3'b010;
        endcase
    endfunction
    function automatic logic [24:0] model(int st, logic r, logic rs);
        logic pcw, pcc, iord, mrw, mio, irw, rw;
        logic [1:0] pcs, m2r, sa, sb, imm;
        logic [2:0] alu;
        logic [3:0] s4;
        {pcw, pcc, iord, mrw, mio, irw, rw} = 7'b0;
        {pcs, m2r, sa, sb, imm} = 10'b0;
        alu = 3'b000;
        case (st)
            0:  begin mio = 1; sb = 2'b01; alu = 3'b010; irw = r; pcw = r; end
            1:  begin sa = 2'b10; sb = 2'b10; alu = 3'b010;
                      imm = op_c == OP_BR ? 2'b10 : op_c == OP_JAL ? 2'b11 : 2'b00; end
            2:  begin sa = 2'b01; alu = ref_r(f3_c, f7_c); end
            3:  begin sa = 2'b01; sb = 2'b10; alu = ref_i(f3_c); end
            4:  begin sa = 2'b01; sb = 2'b10; alu = 3'b010; imm = op_c == OP_SW ? 2'b01 : 2'b00; end
            5:  begin mio = 1; iord = 1; end
            6:  begin rw = 1; m2r = 2'b01; end
            7:  begin mio = 1; iord = 1; mrw = 1; end
            8:  rw = 1;
            9:  begin sa = 2'b01; alu = 3'b110; pcc = 1; pcs = 2'b01; imm = 2'b10; end
            10: begin rw = 1; m2r = 2'b10; pcw = 1; pcs = 2'b01; imm = 2'b11; end
            default: ;
        endcase
        if (rs) {pcw, pcc, irw, rw, mrw, mio} = 6'b0;
        s4 = 4'(st);
        return {s4, pcw, pcc, pcs, iord, mrw, mio, irw, rw, m2r, sa, sb, imm, alu, ill_exp};
    endfunction
    function automatic logic [24:0] dut_vec();
        return {bus.state_o, bus.PCWrite, bus.PCWriteCond, bus.PCSource, bus.IorD, bus.MemRW,
                bus.CPU_MIO, bus.IRWrite, bus.RegWrite, bus.MemtoReg, bus.ALUSrcA, bus.ALUSrcB,
                bus.ImmSel, bus.ALU_Control, bus.illegal};
    endfunction
    task automatic chk(string tag, logic [31:0] got, logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s t=%0t got=%0h want=%0h", tag, $time, got, want);
        end
    endtask
    initial forever begin
        logic [24:0] exp_v, got_v;
        @(negedge clk or chk_ev);
        if (sbq.size() > 0) begin
            exp_v = sbq.pop_front();
            got_v = dut_vec();
            n_cmp++;
            if (got_v !== exp_v) begin
                n_bad++;
                $display("FAIL ctrl_vec t=%0t op=%b got=%h want=%h", $time, op_c, got_v, exp_v);
            end
        end
    end
    task automatic step(int st, logic r);
        bus.MIO_ready = r;
        sbq.push_back(model(st, r, rst));
        @(posedge clk);
        #1;
    endtask
    task automatic reset_cycles(int n);
        rst = 1'b1;
        ill_exp = 1'b0;
        #1;
        chk("rst_state", bus.state_o, 0);
        chk("rst_mio", bus.CPU_MIO, 0);
        chk("rst_memrw", bus.MemRW, 0);
        chk("rst_illegal", bus.illegal, 0);
        repeat (n) step(0, 1'($urandom_range(0, 1)));
        rst = 1'b0;
    endtask
    task automatic run_instr(logic [4:0] op, logic [2:0] f3, logic f7, bit abort);
        int seq[$];
        bit bad;
        op_c = op; f3_c = f3; f7_c = f7;
        bus.OPcode = op; bus.Fun3 = f3; bus.Fun7 = f7;
        bad = 0;
        seq.push_back(0);
        seq.push_back(1);
        case (op)
            OP_R:    begin seq.push_back(2); seq.push_back(8); end
            OP_I:    begin seq.push_back(3); seq.push_back(8); end
            OP_LW:   begin seq.push_back(4); seq.push_back(5); seq.push_back(6); end
            OP_SW:   begin seq.push_back(4); seq.push_back(7); end
            OP_BR:   seq.push_back(9);
            OP_JAL:  seq.push_back(10);
            default: bad = 1;
        endcase
        foreach (seq[i]) begin
            if (abort && seq[i] == 7) begin
                step(7, 1'b0);
                rst = 1'b1;
                #1;
                chk("abort_state", bus.state_o, 0);
                chk("abort_mio", bus.CPU_MIO, 0);
                chk("abort_memrw", bus.MemRW, 0);
                sbq.push_back(model(0, bus.MIO_ready, 1'b1));
                ->chk_ev;
                @(posedge clk);
                #1;
                reset_cycles(2);
                return;
            end
            if (seq[i] == 0 || seq[i] == 5 || seq[i] == 7) begin
                repeat ($urandom_range(0, 3)) begin
                    step(seq[i], 1'b0);
                    chk("wait_hold", bus.state_o, seq[i]);
                end
                step(seq[i], 1'b1);
            end else step(seq[i], 1'($urandom_range(0, 1)));
        end
`ifdef MCPU_ILLEGAL_TRAP_EN
        if (bad) begin
            ill_exp = 1'b1;
            repeat (5) step(15, 1'($urandom_range(0, 1)));
            chk("trap_state", bus.state_o, 15);
            chk("trap_illegal", bus.illegal, 1);
            reset_cycles(2);
        end
`else
        if (bad) begin
            chk("nop_state", bus.state_o, 0);
            chk("nop_illegal", bus.illegal, 0);
        end
`endif
    endtask
    function automatic logic [4:0] rand_illegal();
        logic [4:0] o;
        do o = 5'($urandom_range(0, 31));
        while (o == OP_R || o == OP_I || o == OP_LW || o == OP_SW || o == OP_BR || o == OP_JAL);
        return o;
    endfunction
    initial begin
        int k;
        bus.OPcode = 5'b0; bus.Fun3 = 3'b0; bus.Fun7 = 1'b0; bus.MIO_ready = 1'b0;
        @(posedge clk);
        #1;
        reset_cycles(2);
        chk("post_rst_state", bus.state_o, 0);
        run_instr(OP_R, 3'b000, 1'b1, 0);
        run_instr(OP_LW, 3'b010, 1'b0, 0);
        run_instr(OP_SW, 3'b010, 1'b0, 0);
        run_instr(OP_BR, 3'b000, 1'b0, 0);
        run_instr(OP_JAL, 3'b000, 1'b0, 0);
        run_instr(OP_SW, 3'b010, 1'b0, 1);
        for (int n = 0; n < 150; n++) begin
            k = $urandom_range(0, 6);
            case (k)
                0: run_instr(OP_R, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 0);
                1: run_instr(OP_I, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 0);
                2: run_instr(OP_LW, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 0);
                3: run_instr(OP_SW, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 0);
                4: run_instr(OP_BR, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 0);
                5: run_instr(OP_JAL, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 0);
`ifdef MCPU_ILLEGAL_TRAP_EN
                default: run_instr(OP_R, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 0);
`else
                default: run_instr(rand_illegal(), 3'b000, 1'b0, 0);
`endif
            endcase
        end
        run_instr(5'b11111, 3'b000, 1'b0, 0);
        run_instr(OP_R, 3'b100, 1'b0, 0);
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
